// File: rtl/mult.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier, one step per clock, result in HI/LO.
// Optional MULT_ZERO_SKIP_EN: zero operand completes on the launch edge without running.
module mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multControl,
  input  logic [WIDTH-1:0] aInput,
  input  logic [WIDTH-1:0] bInput,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH:0]    a_q, a_d, m_q, m_d, sum;
  logic [WIDTH-1:0]  q_q, q_d, hi_q, hi_d, lo_q, lo_d;
  logic              q1_q, q1_d, done_q, done_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              zero_skip;

`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip = (aInput == '0) || (bInput == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // A carries one guard bit so subtracting M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    unique case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (multControl) begin
          if (zero_skip) begin
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            a_d     = '0;
            q_d     = bInput;
            q1_d    = 1'b0;
            m_d     = {aInput[WIDTH-1], aInput};
            cnt_d   = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!multControl) begin
          state_d = StIdle;
        end else begin
          a_d   = {sum[WIDTH], sum[WIDTH:1]};
          q_d   = {sum[0], q_q[WIDTH-1:1]};
          q1_d  = q_q[0];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            hi_d    = a_d[WIDTH-1:0];
            lo_d    = q_d;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Held control never relaunches; a new op needs multControl low first.
        if (!multControl) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: directed corner products, abort/reset, and random operands
// against a plain signed-multiply reference.
module tb_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        multControl;
  logic [31:0] aInput, bInput;
  logic [31:0] HI, LO;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  mult #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .multControl(multControl),
    .aInput     (aInput),
    .bInput     (bInput),
    .HI         (HI),
    .LO         (LO),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation: launch, run to done with operands scrambled, check result/latency/pulse.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic signed [63:0] sa, sb, prod;
    int lat, busy_cnt, exp_lat;
    sa   = $signed(a);
    sb   = $signed(b);
    prod = sa * sb;
    exp_lat = 32;
`ifdef MULT_ZERO_SKIP_EN
    if (a == 0 || b == 0) exp_lat = 0;
`endif
    @(negedge clk);
    multControl = 1'b1;
    aInput = a;
    bInput = b;
    step();  // E0
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      aInput = $urandom;
      bInput = $urandom;
      step();
      lat++;
    end
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, ".HI"}, 64'(HI), 64'(prod[63:32]));
    check({tag, ".LO"}, 64'(LO), 64'(prod[31:0]));
    step();  // held high in DONE: pulse ends, no relaunch
    check({tag, ".done_pulse_end"}, 64'(done), 64'd0);
    check({tag, ".no_relaunch"}, 64'(busy), 64'd0);
    check({tag, ".hold"}, {HI, LO}, prod);
    multControl = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    multControl = 1'b0;
    aInput = '0;
    bInput = '0;
    #12;
    check("rst.HI", 64'(HI), 64'd0);
    check("rst.LO", 64'(LO), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(32'd7, 32'd6, "7x6");

    // Abort after E10: HI/LO keep 0/0x2A, no done.
    @(negedge clk);
    multControl = 1'b1;
    aInput = 32'd9;
    bInput = 32'd9;
    step();  // E0
    for (int i = 0; i < 10; i++) step();
    check("abort.busy_before", 64'(busy), 64'd1);
    multControl = 1'b0;
    step();
    check("abort.busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort.no_done", 64'(done), 64'd0);
      step();
    end
    check("abort.hold", {HI, LO}, 64'h0000_0000_0000_002A);

    // Relaunch, then asynchronous reset after E5.
    @(negedge clk);
    multControl = 1'b1;
    step();  // E0
    for (int i = 0; i < 5; i++) step();
    #2;
    reset = 1'b1;
    #1;
    check("arst.HILO", {HI, LO}, 64'd0);
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.done", 64'(done), 64'd0);
    multControl = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    do_op(32'hFFFF_FFFD, 32'd5, "m3x5");
    do_op(32'h8000_0000, 32'h8000_0000, "minxmin");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, "minxm1");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "m1xm1");
    do_op(32'd7, 32'd6, "7x6b");
    do_op(32'd0, 32'h0000_1234, "zeroa");
    do_op(32'h0000_1234, 32'd0, "zerob");
    for (int i = 0; i < 8; i++) do_op($urandom, $urandom, $sformatf("rnd%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
